// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and constants for the 6502 bus RAM slice.
//   state_t      - controller states (IDLE, WAIT)
//   VEC_RESET_LO - address of the reset vector low byte
//   VEC_RESET_HI - address of the reset vector high byte
//   cnt_width()  - wait-state counter width, never below one bit
package cpu_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
  localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;

  function automatic int unsigned cnt_width(input int unsigned ws);
    int unsigned w;
    w = $clog2(ws + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cpu_bus_mem_array.sv
// cpu_bus_mem_array: synchronous single-port RAM, registered read, write-first.
//   i_clk   - clock
//   i_we    - write enable
//   i_addr  - word index
//   i_wdata - write data
//   o_rdata - read data, registered; shows i_wdata on a write edge
// Contents are never cleared.
module cpu_bus_mem_array #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      o_rdata       <= i_wdata;
    end else begin
      o_rdata       <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/cpu_bus_mem.sv
// cpu_bus_mem: windowed bus RAM for the 6502 CPU bus with programmable read
// wait states (driving RDY), reset-vector override and open-bus reads.
//   i_clk     - system clock
//   i_reset_n - asynchronous active-low reset
//   i_phi2    - one-clock strobe marking each CPU bus sample point
//   i_rw      - 1 = read, 0 = write
//   i_addr    - bus address
//   i_data    - write data
//   o_data    - registered read data
//   o_rdy     - to CPU RDY; low = stall
//   o_hit     - 1 = last sampled access was in the window or a vector
module cpu_bus_mem
  import cpu_bus_pkg::*;
#(
  parameter int unsigned        ADDR_W       = 16,
  parameter int unsigned        DATA_W       = 8,
  parameter int unsigned        DEPTH_LOG2   = 12,
  parameter logic [ADDR_W-1:0]  BASE_ADDR    = 16'h0000,
  parameter int unsigned        WAIT_STATES  = 0,
  parameter bit                 VEC_OVERRIDE = 1'b1,
  parameter logic [15:0]        RESET_VECTOR = 16'h0400,
  parameter logic [DATA_W-1:0]  OPEN_BUS     = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_phi2,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_rdy,
  output logic              o_hit
);

  localparam int unsigned     CNT_W  = cnt_width(WAIT_STATES);
  localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WAIT_STATES);

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx_nxt;
  logic [DATA_W-1:0]     r_data, w_data_nxt;
  logic                  r_rdy, w_rdy_nxt;
  logic                  r_hit, w_hit_nxt;
  logic                  r_load, w_load_nxt;

  logic                  w_in_win;
  logic                  w_is_vec;
  logic                  w_we;
  logic                  w_done;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DEPTH_LOG2-1:0] w_ram_addr;
  logic [DATA_W-1:0]     w_rdata;
  logic [DATA_W-1:0]     w_vec_byte;

  // Decode
  assign w_in_win   = (i_addr[ADDR_W-1:DEPTH_LOG2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2]);
  assign w_is_vec   = VEC_OVERRIDE && i_rw &&
                      ((i_addr == ADDR_W'(VEC_RESET_LO)) || (i_addr == ADDR_W'(VEC_RESET_HI)));
  assign w_vec_byte = i_addr[0] ? DATA_W'(RESET_VECTOR[15:8]) : DATA_W'(RESET_VECTOR[7:0]);
  assign w_idx      = i_addr[DEPTH_LOG2-1:0];
  assign w_done     = (r_cnt == CNT_W'(1));

  // A stalled read keeps the RAM pointed at the latched index; a write
  // (legal or a stall-cancelling one) always goes to the live address.
  assign w_ram_addr = ((r_state == WAIT) && i_rw) ? r_idx : w_idx;
  assign w_we       = i_phi2 && !i_rw && w_in_win;

  cpu_bus_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_addr  (w_ram_addr),
    .i_wdata (i_data),
    .o_rdata (w_rdata)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (i_phi2) begin
      case (r_state)
        IDLE: begin
          if (i_rw && !w_is_vec && w_in_win && (WAIT_STATES != 0))
            w_state_nxt = WAIT;
        end
        WAIT: begin
          if (!i_rw || w_done)
            w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  // The RAM read is registered, so a memory read sets r_load at the strobe
  // edge and o_data takes the RAM output on the following clock; a strobe on
  // that same clock still sees the pending load as its default.
  always_comb begin
    w_data_nxt = r_load ? w_rdata : r_data;
    w_load_nxt = 1'b0;
    w_rdy_nxt  = r_rdy;
    w_hit_nxt  = r_hit;
    w_cnt_nxt  = r_cnt;
    w_idx_nxt  = r_idx;
    if (i_phi2) begin
      case (r_state)
        IDLE: begin
          if (w_is_vec) begin
            w_data_nxt = w_vec_byte;
            w_hit_nxt  = 1'b1;
          end else if (!w_in_win) begin
            w_hit_nxt = 1'b0;
            if (i_rw)
              w_data_nxt = OPEN_BUS;
          end else if (!i_rw) begin
            w_hit_nxt = 1'b1;
          end else if (WAIT_STATES == 0) begin
            w_load_nxt = 1'b1;
            w_hit_nxt  = 1'b1;
          end else begin
            w_idx_nxt = w_idx;
            w_cnt_nxt = WS_CNT;
            w_rdy_nxt = 1'b0;
            w_hit_nxt = 1'b1;
          end
        end
        WAIT: begin
          if (!i_rw) begin
            w_rdy_nxt = 1'b1;
            w_hit_nxt = w_in_win;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (w_done) begin
              w_load_nxt = 1'b1;
              w_rdy_nxt  = 1'b1;
              w_hit_nxt  = 1'b1;
            end
          end
        end
        default: begin
          w_rdy_nxt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data <= OPEN_BUS;
      r_rdy  <= 1'b1;
      r_hit  <= 1'b0;
      r_load <= 1'b0;
      r_cnt  <= '0;
      r_idx  <= '0;
    end else begin
      r_data <= w_data_nxt;
      r_rdy  <= w_rdy_nxt;
      r_hit  <= w_hit_nxt;
      r_load <= w_load_nxt;
      r_cnt  <= w_cnt_nxt;
      r_idx  <= w_idx_nxt;
    end
  end

  assign o_data = r_data;
  assign o_rdy  = r_rdy;
  assign o_hit  = r_hit;

endmodule

// File: tb/tb_cpu_bus_mem.sv
// tb_cpu_bus_mem: directed bench for cpu_bus_mem.
// Three instances share clock and reset, each with its own bus:
//   u0 - defaults (no wait states, window $0000-$0FFF, vector override on)
//   u1 - WAIT_STATES=2, window $0000-$0FFF
//   u2 - WAIT_STATES=3, window $1000-$1FFF, vector override off
module tb_cpu_bus_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       phi2 [3];
  logic       rw   [3];
  logic [15:0] addr [3];
  logic [7:0] wd   [3];
  logic [7:0] dout [3];
  logic       rdy  [3];
  logic       hit  [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_bus_mem u0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_phi2(phi2[0]), .i_rw(rw[0]),
    .i_addr(addr[0]), .i_data(wd[0]), .o_data(dout[0]), .o_rdy(rdy[0]), .o_hit(hit[0])
  );

  cpu_bus_mem #(.WAIT_STATES(2)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_phi2(phi2[1]), .i_rw(rw[1]),
    .i_addr(addr[1]), .i_data(wd[1]), .o_data(dout[1]), .o_rdy(rdy[1]), .o_hit(hit[1])
  );

  cpu_bus_mem #(.WAIT_STATES(3), .BASE_ADDR(16'h1000), .VEC_OVERRIDE(1'b0)) u2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_phi2(phi2[2]), .i_rw(rw[2]),
    .i_addr(addr[2]), .i_data(wd[2]), .o_data(dout[2]), .o_rdy(rdy[2]), .o_hit(hit[2])
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One bus cycle: strobe for one clock, then a one-clock gap; returns on a
  // falling edge after the registered outputs have settled.
  task automatic strobe(input int k, input logic r, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    rw[k]   = r;
    addr[k] = a;
    wd[k]   = d;
    phi2[k] = 1'b1;
    @(negedge clk);
    phi2[k] = 1'b0;
    @(negedge clk);
  endtask

  // Stalled read spanning ws+1 strobes; the address moves during the stall.
  task automatic rd_stall(input int k, input logic [15:0] a, input int ws,
                          input logic [7:0] exp, input logic [7:0] prev, input string tag);
    strobe(k, 1'b1, a, 8'h00);
    chk({tag, " start rdy"}, rdy[k], 1'b0);
    chk({tag, " start data"}, dout[k], prev);
    for (int i = 1; i < ws; i++) begin
      strobe(k, 1'b1, a + 16'(16'h0010 * i), 8'h00);
      chk({tag, " mid rdy"}, rdy[k], 1'b0);
    end
    strobe(k, 1'b1, a + 16'(16'h0010 * ws), 8'h00);
    chk({tag, " end rdy"}, rdy[k], 1'b1);
    chk({tag, " end data"}, dout[k], exp);
    chk({tag, " end hit"}, hit[k], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      phi2[k] = 1'b0;
      rw[k]   = 1'b1;
      addr[k] = 16'h0000;
      wd[k]   = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset defaults
    for (int k = 0; k < 3; k++) begin
      chk("reset data", dout[k], 8'hFF);
      chk("reset rdy", rdy[k], 1'b1);
      chk("reset hit", hit[k], 1'b0);
    end

    // u0: zero-wait write/read, vectors, window edges
    strobe(0, 1'b0, 16'h0200, 8'hA5);
    chk("u0 wr hit", hit[0], 1'b1);
    chk("u0 wr rdy", rdy[0], 1'b1);
    strobe(0, 1'b1, 16'h0200, 8'h00);
    chk("u0 rd 0200", dout[0], 8'hA5);
    chk("u0 rd rdy", rdy[0], 1'b1);
    chk("u0 rd hit", hit[0], 1'b1);
    strobe(0, 1'b0, 16'h0201, 8'h5A);
    strobe(0, 1'b1, 16'h0201, 8'h00);
    chk("u0 rd 0201", dout[0], 8'h5A);
    strobe(0, 1'b0, 16'h0FFF, 8'hC3);
    strobe(0, 1'b1, 16'h0FFF, 8'h00);
    chk("u0 rd 0FFF", dout[0], 8'hC3);
    strobe(0, 1'b1, 16'h1000, 8'h00);
    chk("u0 rd 1000 open", dout[0], 8'hFF);
    chk("u0 rd 1000 hit", hit[0], 1'b0);
    strobe(0, 1'b1, 16'hFFFC, 8'h00);
    chk("u0 vec lo", dout[0], 8'h00);
    chk("u0 vec lo hit", hit[0], 1'b1);
    chk("u0 vec lo rdy", rdy[0], 1'b1);
    strobe(0, 1'b1, 16'hFFFD, 8'h00);
    chk("u0 vec hi", dout[0], 8'h04);
    chk("u0 vec hi rdy", rdy[0], 1'b1);
    strobe(0, 1'b1, 16'h0200, 8'h00);
    chk("u0 rd 0200 again", dout[0], 8'hA5);

    // u1: two wait states, address changes during stall, stall-write cancel
    strobe(1, 1'b0, 16'h0010, 8'h3C);
    chk("u1 wr rdy", rdy[1], 1'b1);
    strobe(1, 1'b0, 16'h0020, 8'h11);
    rd_stall(1, 16'h0010, 2, 8'h3C, 8'hFF, "u1 rd 0010");
    strobe(1, 1'b1, 16'h0020, 8'h00);
    chk("u1 cancel start rdy", rdy[1], 1'b0);
    strobe(1, 1'b0, 16'h0040, 8'hE1);
    chk("u1 cancel rdy", rdy[1], 1'b1);
    chk("u1 cancel data", dout[1], 8'h3C);
    chk("u1 cancel hit", hit[1], 1'b1);
    rd_stall(1, 16'h0040, 2, 8'hE1, 8'h3C, "u1 rd 0040");

    // u2: window $1000, no aliasing, no vector override
    strobe(2, 1'b0, 16'h1000, 8'h42);
    chk("u2 wr 1000 hit", hit[2], 1'b1);
    strobe(2, 1'b0, 16'h2000, 8'h77);
    chk("u2 wr 2000 hit", hit[2], 1'b0);
    chk("u2 wr 2000 rdy", rdy[2], 1'b1);
    strobe(2, 1'b1, 16'h2000, 8'h00);
    chk("u2 rd 2000 open", dout[2], 8'hFF);
    chk("u2 rd 2000 hit", hit[2], 1'b0);
    chk("u2 rd 2000 rdy", rdy[2], 1'b1);
    rd_stall(2, 16'h1000, 3, 8'h42, 8'hFF, "u2 rd 1000");
    strobe(2, 1'b1, 16'hFFFC, 8'h00);
    chk("u2 vec off data", dout[2], 8'hFF);
    chk("u2 vec off hit", hit[2], 1'b0);
    chk("u2 vec off rdy", rdy[2], 1'b1);

    // u2: reset during a stall
    strobe(2, 1'b0, 16'h1004, 8'h9D);
    strobe(2, 1'b1, 16'h1004, 8'h00);
    chk("u2 pre-reset rdy", rdy[2], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("u2 async rdy", rdy[2], 1'b1);
    chk("u2 async data", dout[2], 8'hFF);
    chk("u2 async hit", hit[2], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_stall(2, 16'h1000, 3, 8'h42, 8'hFF, "u2 post-reset 1000");
    rd_stall(2, 16'h1004, 3, 8'h9D, 8'h42, "u2 post-reset 1004");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
